// File: rtl/pwm_track_player.sv
// Multi-track PWM audio player: fetches samples from a synchronous memory and plays one track.
// Optional per-channel attenuation (vol port) is compiled in when PWM_PLAYER_VOLUME_EN is defined.

module pwm_track_player #(
    parameter int SAMPLE_W   = 11,
    parameter int ADDR_W     = 12,
    parameter int NUM_TRACKS = 4,
    parameter int TRK_W      = 2,
    parameter int CHANNELS   = 2,
    parameter int PWM_TOP    = 700,
    parameter int DIV_W      = 16
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         loop,
    input  logic [TRK_W-1:0]             track_sel,
    input  logic [NUM_TRACKS*ADDR_W-1:0] track_base,
    input  logic [NUM_TRACKS*ADDR_W-1:0] track_last,
    input  logic [DIV_W-1:0]             div_val,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [SAMPLE_W-1:0]          mem_data,
`ifdef PWM_PLAYER_VOLUME_EN
    input  logic [CHANNELS*3-1:0]        vol,
`endif
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         busy,
    output logic                         done,
    output logic [TRK_W-1:0]             cur_track
);

    localparam int CNT_W = (PWM_TOP < 2) ? 1 : $clog2(PWM_TOP + 1);
    localparam int CMP_W = (SAMPLE_W > CNT_W) ? SAMPLE_W : CNT_W;
    localparam int NSEL  = 1 << TRK_W;
    localparam logic [CNT_W-1:0] TOP_C = CNT_W'(PWM_TOP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD1,
        S_LOAD2,
        S_PLAY,
        S_PAUSE
    } state_t;

    state_t                state_q, state_d;
    logic [TRK_W-1:0]      cur_track_q, cur_track_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [SAMPLE_W-1:0]   duty_q, duty_d;
    logic [SAMPLE_W-1:0]   next_q, next_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0]   pwm_out_q, pwm_out_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  pf_q, pf_d;
    logic                  cap_q, cap_d;

    // Track table unpacked into arrays; unused select codes read as address 0.
    logic [ADDR_W-1:0] base_arr [NSEL];
    logic [ADDR_W-1:0] last_arr [NSEL];

    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_trk
            if (gi < NUM_TRACKS) begin : g_used
                assign base_arr[gi] = track_base[gi*ADDR_W +: ADDR_W];
                assign last_arr[gi] = track_last[gi*ADDR_W +: ADDR_W];
            end else begin : g_pad
                assign base_arr[gi] = '0;
                assign last_arr[gi] = '0;
            end
        end
    endgenerate

    logic [ADDR_W-1:0] cur_base, cur_last, sel_base;
    logic [ADDR_W-1:0] addr_nx, addr_nnx;
    logic [DIV_W-1:0]  div_term;
    logic              tick, at_last, wrap;

    assign cur_base = base_arr[cur_track_q];
    assign cur_last = last_arr[cur_track_q];
    assign sel_base = base_arr[track_sel];
    assign at_last  = (addr_q == cur_last);
    assign addr_nx  = at_last ? cur_base : addr_q + ADDR_W'(1);
    assign addr_nnx = (addr_nx == cur_last) ? cur_base : addr_nx + ADDR_W'(1);
    assign div_term = (div_val == '0) ? '0 : div_val - DIV_W'(1);
    assign tick     = (div_cnt_q >= div_term);
    assign wrap     = tick && (pwm_cnt_q == TOP_C);

    always_comb begin
        state_d     = state_q;
        cur_track_d = cur_track_q;
        addr_d      = addr_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        duty_d      = duty_q;
        next_d      = next_q;
        div_cnt_d   = div_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        done_d      = 1'b0;
        pf_d        = 1'b0;
        cap_d       = pf_q;

        // Prefetched sample arrives the cycle after its read strobe.
        if (cap_q) begin
            next_d = mem_data;
        end

        case (state_q)
            S_IDLE: begin
                cap_d = 1'b0;
            end
            S_LOAD1: begin
                state_d = S_LOAD2;
            end
            S_LOAD2: begin
                duty_d     = mem_data;
                state_d    = S_PLAY;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_nx;
                pf_d       = 1'b1;
                div_cnt_d  = '0;
                pwm_cnt_d  = '0;
            end
            S_PLAY: begin
                // The current cycle is always consumed, even when pause arrives now.
                state_d = pause ? S_PAUSE : S_PLAY;
                if (!tick) begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!wrap) begin
                        pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
                    end else begin
                        pwm_cnt_d = '0;
                        duty_d    = cap_q ? mem_data : next_q;
                        if (at_last && !loop) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            cap_d   = 1'b0;
                        end else begin
                            addr_d     = addr_nx;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_nnx;
                            pf_d       = 1'b1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (!pause) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Control overrides: stop beats start, start beats everything below it.
        if (stop) begin
            state_d  = S_IDLE;
            mem_rd_d = 1'b0;
            done_d   = 1'b0;
            pf_d     = 1'b0;
            cap_d    = 1'b0;
        end else if (start) begin
            state_d     = S_LOAD1;
            cur_track_d = track_sel;
            addr_d      = sel_base;
            mem_rd_d    = 1'b1;
            mem_addr_d  = sel_base;
            div_cnt_d   = '0;
            pwm_cnt_d   = '0;
            done_d      = 1'b0;
            pf_d        = 1'b0;
            cap_d       = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    logic [CMP_W-1:0] cnt_ext;
    assign cnt_ext = CMP_W'(pwm_cnt_d);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SAMPLE_W-1:0] duty_ch;
`ifdef PWM_PLAYER_VOLUME_EN
            assign duty_ch = duty_d >> vol[gi*3 +: 3];
`else
            assign duty_ch = duty_d;
`endif
            assign pwm_out_d[gi] = (state_d == S_PLAY) && (CMP_W'(duty_ch) > cnt_ext);
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cur_track_q <= '0;
            addr_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            duty_q      <= '0;
            next_q      <= '0;
            div_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            pwm_out_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            pf_q        <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_track_q <= cur_track_d;
            addr_q      <= addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            duty_q      <= duty_d;
            next_q      <= next_d;
            div_cnt_q   <= div_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pwm_out_q   <= pwm_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            pf_q        <= pf_d;
            cap_q       <= cap_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign pwm_out   = pwm_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_track = cur_track_q;

endmodule

// File: tb/tb_pwm_track_player.sv
// Testbench for pwm_track_player: playback table plus pause/stop/restart/reset sequences.
// Per-period results are checked against a scoreboard of expected {fetch addr, highs, length}.

module tb_pwm_track_player;

    localparam int SW  = 11;
    localparam int AW  = 12;
    localparam int NT  = 4;
    localparam int TW  = 2;
    localparam int CH  = 2;
    localparam int TOP = 9;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, stop, pause, loop;
    logic [TW-1:0]     track_sel;
    logic [NT*AW-1:0]  track_base, track_last;
    logic [DW-1:0]     div_val;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [SW-1:0]     mem_data;
    logic [CH-1:0]     pwm_out;
    logic              busy, done;
    logic [TW-1:0]     cur_track;

`ifdef PWM_PLAYER_VOLUME_EN
    localparam int SH1 = 1;
    logic [CH*3-1:0] vol;
    assign vol = {3'd1, 3'd0};
`else
    localparam int SH1 = 0;
`endif

    always #5 clk = ~clk;

    pwm_track_player #(
        .SAMPLE_W(SW), .ADDR_W(AW), .NUM_TRACKS(NT), .TRK_W(TW),
        .CHANNELS(CH), .PWM_TOP(TOP), .DIV_W(DW)
    ) dut (
        .CLOCK_50(clk), .RESET(rst), .start(start), .stop(stop), .pause(pause),
        .loop(loop), .track_sel(track_sel), .track_base(track_base),
        .track_last(track_last), .div_val(div_val), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef PWM_PLAYER_VOLUME_EN
        .vol(vol),
`endif
        .pwm_out(pwm_out), .busy(busy), .done(done), .cur_track(cur_track)
    );

    // Synchronous sample memory: data valid the cycle after the strobe.
    logic [SW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int tbase[4] = '{0, 4, 10, 20};
    int tlast[4] = '{2, 4, 11, 22};

    typedef struct {
        int addr;
        int h0;
        int h1;
        int len;
    } seg_t;

    typedef struct {
        int trk;
        bit lp;
        int dv;
        int nper;
        int exp_done;
    } vec_t;

    seg_t sb[$];
    vec_t vt[8];

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    int done_cnt = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected behaviour: LOAD segment, then one segment per period.
    task automatic push_play(input int trk, input bit lp, input int dv, input int nper);
        int d, n, p, s;
        d = (dv == 0) ? 1 : dv;
        n = tlast[trk] - tbase[trk] + 1;
        p = lp ? nper : n;
        sb.push_back('{tbase[trk], 0, 0, 2});
        for (int k = 1; k <= p; k++) begin
            s = int'(mem[tbase[trk] + (k - 1) % n]);
            sb.push_back('{tbase[trk] + k % n, imin(s, TOP + 1) * d,
                           imin(s >> SH1, TOP + 1) * d, (TOP + 1) * d});
        end
    endtask

    // Monitor: a segment starts at each read strobe and ends at the next strobe or busy fall.
    seg_t cur;
    bit   open = 0;
    bit   prev_busy = 0;

    task automatic close_seg();
        seg_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL seg_unexpected: addr=%0d h0=%0d h1=%0d len=%0d", cur.addr, cur.h0, cur.h1, cur.len);
        end else begin
            e = sb.pop_front();
            if (cur.addr != e.addr || cur.h0 != e.h0 || cur.h1 != e.h1 || cur.len != e.len) begin
                errors++;
                $display("FAIL seg: got addr=%0d h0=%0d h1=%0d len=%0d expected addr=%0d h0=%0d h1=%0d len=%0d",
                         cur.addr, cur.h0, cur.h1, cur.len, e.addr, e.h0, e.h1, e.len);
            end
        end
        open = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                open = 0;
            end else begin
                if (open && (mem_rd || (prev_busy && !busy))) close_seg();
                if (mem_rd) begin
                    open = 1;
                    cur = '{int'(mem_addr), 0, 0, 0};
                end
                if (busy && open) begin
                    cur.len++;
                    cur.h0 += int'(pwm_out[0]);
                    cur.h1 += int'(pwm_out[1]);
                end
            end
            if (done) done_cnt++;
            prev_busy = busy;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse(input int trk);
        track_sel = TW'(trk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_rd", int'(mem_rd), 1);
        chk("start_addr", int'(mem_addr), tbase[trk]);
        chk("start_trk", int'(cur_track), trk);
    endtask

    task automatic wait_idle(input int lim);
        int t = 0;
        while (busy && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_sb(input int lim);
        int t = 0;
        while (sb.size() != 0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic stop_now();
        mon_en = 0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_pwm", int'(pwm_out), 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vt[idx];
        sb.delete();
        done_cnt = 0;
        loop = v.lp;
        div_val = DW'(v.dv);
        push_play(v.trk, v.lp, v.dv, v.nper);
        mon_en = 1;
        start_pulse(v.trk);
        if (!v.lp) begin
            wait_idle(4000);
            cyc(2);
            chk("vec_drained", sb.size(), 0);
        end else begin
            wait_sb(4000);
            stop_now();
            cyc(2);
        end
        chk("vec_done", done_cnt, v.exp_done);
        mon_en = 0;
        loop = 1'b0;
        sb.delete();
        $display("vec %0d trk=%0d loop=%0d div=%0d checked", idx, v.trk, v.lp, v.dv);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 1'b0, 1, 0, 1};
        vt[1] = '{0, 1'b1, 1, 5, 0};
        vt[2] = '{0, 1'b0, 0, 0, 1};
        vt[3] = '{0, 1'b0, 4, 0, 1};
        vt[4] = '{1, 1'b0, 1, 0, 1};
        vt[5] = '{1, 1'b1, 1, 3, 0};
        vt[6] = '{3, 1'b0, 2, 0, 1};
        vt[7] = '{2, 1'b0, 1, 0, 1};

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[0] = 11'd3;  mem[1] = 11'd0;  mem[2] = 11'd12;
        mem[4] = 11'd7;
        mem[10] = 11'd5; mem[11] = 11'd1;
        mem[20] = 11'd9; mem[21] = 11'd8; mem[22] = 11'd6;
        for (int i = 0; i < NT; i++) begin
            track_base[i*AW +: AW] = AW'(tbase[i]);
            track_last[i*AW +: AW] = AW'(tlast[i]);
        end

        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
        track_sel = '0; div_val = DW'(1);
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd", int'(mem_rd), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_trk", int'(cur_track), 0);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Pause at pwm count 4 for 20 cycles on a looped single-sample track (sample 7).
        sb.delete();
        done_cnt = 0;
        loop = 1'b1;
        div_val = DW'(1);
        sb.push_back('{4, 0, 0, 2});
        sb.push_back('{4, 7, imin(7 >> SH1, TOP + 1), TOP + 1 + 20});
        sb.push_back('{4, 7, imin(7 >> SH1, TOP + 1), TOP + 1});
        mon_en = 1;
        start_pulse(1);
        begin
            int hc = 0, t = 0, z = 0;
            while (hc < 4 && t < 50) begin
                @(negedge clk);
                if (pwm_out[0]) hc++;
                t++;
            end
            chk("pause_reach", hc, 4);
            pause = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pwm_out != '0 || !busy) z++;
            end
            chk("pause_low", z, 0);
            pause = 1'b0;
        end
        wait_sb(200);
        stop_now();
        loop = 1'b0;
        cyc(2);
        chk("pause_done", done_cnt, 0);
        $display("seq pause checked");

        // Simultaneous start and stop during PLAY: stop wins.
        mon_en = 0;
        done_cnt = 0;
        start_pulse(0);
        cyc(12);
        track_sel = TW'(2);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_rd", int'(mem_rd), 0);
        chk("ss_pwm", int'(pwm_out), 0);
        cyc(3);
        chk("ss_done", done_cnt, 0);
        start_pulse(2);
        stop_now();
        cyc(2);
        $display("seq start_stop checked");

        // Restart while busy: the new track plays from its base.
        sb.delete();
        done_cnt = 0;
        start_pulse(0);
        cyc(14);
        push_play(3, 1'b0, 1, 0);
        mon_en = 1;
        start_pulse(3);
        wait_idle(2000);
        cyc(2);
        chk("restart_drained", sb.size(), 0);
        chk("restart_done", done_cnt, 1);
        mon_en = 0;
        $display("seq restart checked");

        // Reset in the middle of PLAY, then a clean replay from track_base.
        start_pulse(2);
        cyc(13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rd", int'(mem_rd), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_trk", int'(cur_track), 0);
        chk("mid_rst_done", int'(done), 0);
        cyc(2);
        run_vec(7);
        $display("seq reset checked");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_track_player.md
Name: pwm_track_player

Overview:
- Parametrised multi-track PWM audio player: fetches samples from an external synchronous sample memory and plays one selected track through CHANNELS PWM outputs.
- Track boundaries come from a packed table; tick rate comes from a runtime divider.
- Adds start/stop/pause control, loop mode, a done pulse and a prefetched sample pipeline.
- Sits between the board switch/key decode logic and the GPIO audio pins.

Parameters:
- SAMPLE_W, 11, sample and PWM duty width.
- ADDR_W, 12, sample memory address width.
- NUM_TRACKS, 4, number of track-table entries.
- TRK_W, 2, track select width; must satisfy 2**TRK_W >= NUM_TRACKS.
- CHANNELS, 2, number of identical PWM outputs.
- PWM_TOP, 700, PWM counter terminal value; the period is PWM_TOP+1 ticks.
- DIV_W, 16, tick divider width.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin playing track_sel.
- stop  in  1  level: abort playback.
- pause  in  1  level: hold playback position.
- loop  in  1  level: repeat the track at its end.
- track_sel  in  TRK_W  track index, latched on start.
- track_base  in  NUM_TRACKS*ADDR_W  first address of each track (entry i at [i*ADDR_W +: ADDR_W]).
- track_last  in  NUM_TRACKS*ADDR_W  last address of each track, inclusive.
- div_val  in  DIV_W  system clocks per PWM tick; 0 is treated as 1.
- mem_rd  out  1  sample memory read strobe.
- mem_addr  out  ADDR_W  sample memory address.
- mem_data  in  SAMPLE_W  read data, valid exactly 1 cycle after mem_rd.
- pwm_out  out  CHANNELS  PWM audio outputs.
- busy  out  1  high in LOAD, PLAY or PAUSE.
- done  out  1  one-cycle pulse at the end of a non-looped track.
- cur_track  out  TRK_W  latched track index.

Behaviour:
- Reset (sync, highest priority) clears all state:
  - state=IDLE; pwm_out=0, mem_rd=0, mem_addr=0, busy=0, done=0, cur_track=0.
  - Internal counters, duty_reg and next_reg cleared to 0.
- States and transitions:
  - IDLE: outputs low. start -> LOAD.
  - LOAD: 2 cycles.
    - Cycle 1: latch cur_track=track_sel and addr=track_base[track_sel]; drive mem_rd=1, mem_addr=addr.
    - Cycle 2: duty_reg<=mem_data; -> PLAY.
  - PLAY: normal playback (see below). pause=1 -> PAUSE.
  - PAUSE: tick divider, PWM counter and addr frozen; pwm_out held 0. pause=0 -> PLAY, resuming the same counter value.
- Priority (highest first): RESET, stop, start, pause.
  - stop in any non-IDLE state -> IDLE next cycle; outputs low; no done pulse.
  - start while busy restarts LOAD with the new track_sel; the old position is discarded.
  - Simultaneous start and stop: stop wins.
- PLAY datapath:
  - The tick divider counts 0..max(div_val,1)-1 and emits a one-cycle tick at the terminal count.
  - On each tick the PWM counter increments; at PWM_TOP it wraps to 0.
  - pwm_out[c] = (duty_reg > pwm_cnt) for every channel, registered, 1-cycle latency.
  - Duty 0 gives constant low; duty > PWM_TOP gives constant high (saturation is implicit in the compare).
- Prefetch:
  - On the first PLAY cycle after LOAD, and on every wrap, issue mem_rd for addr+1, or for track_base if addr==track_last.
  - Capture next_reg on the following cycle.
  - The PWM period is at least 2 ticks, so next_reg is always valid before the next wrap.
- At wrap:
  - duty_reg<=next_reg; addr advances.
  - If the wrap was at addr==track_last: loop=1 -> addr=track_base and continue; loop=0 -> done=1 for one cycle and go to IDLE.
- A single-sample track (track_base==track_last) plays one period, then ends or repeats.
- Address arithmetic is mod 2**ADDR_W.
- track_base > track_last is illegal; behaviour is undefined.
- div_val is sampled continuously; a change takes effect at the next divider terminal count.
- mem_rd is high for exactly 1 cycle per fetch; mem_addr holds its value between fetches.

Optional Feature:
- Macro: PWM_PLAYER_VOLUME_EN.
- When defined:
  - Adds input port vol, CHANNELS*3 bits wide.
  - Channel c compares (duty_reg >> vol[c*3 +: 3]) against pwm_cnt; shift 0 means full scale, shift 7 means heavy attenuation.
- When undefined: the port is absent and all channels use unshifted duty_reg.

Test Plan:
- PWM_TOP=9, div_val=1, track 0 at base 0/last 2 with samples 3,0,12; start. Required: busy on the next cycle; pwm_out high 3 of 10 ticks, then 0 of 10, then 10 of 10 (saturated); done pulse after the third period; back to IDLE.
- Same track with loop=1 for 5 periods. Required: mem_addr sequence 0,1,2,0,1,2; no done pulse.
- Pause asserted mid-period at pwm_cnt=4 for 20 cycles, then released. Required: pwm_out=0 and counter frozen at 4 while paused; playback resumes at 4 with the same duty.
- start and stop asserted in the same cycle during PLAY. Required: IDLE next cycle, no done; then start with track_sel=2 loads track_base[2].
- div_val=0 versus div_val=1. Required: identical timing. div_val=4: every tick is 4 clocks apart.
- RESET asserted mid-PLAY. Required: all outputs 0 on the next edge; the next start plays from track_base. With PWM_PLAYER_VOLUME_EN, vol=1 on channel 1 with sample 8: channel 0 high 8 ticks, channel 1 high 4 ticks.
